// File: rtl/cpu_ctrl.sv
// cpu_ctrl: SimpleCPU control unit. Fetches and decodes 16-bit
// instructions and drives the register file, ALU and data memory.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   I_addr, I_rd       instruction fetch address (PC) and read strobe
//   I_data             instruction word, combinational read
//   D_addr, D_rd, D_wr data-memory address and strobes
//   RF_s               W_data source: 00 ALU, 01 data memory, 10 const
//   RF_W_data          LOADC constant (zero-extended by datapath)
//   RF_W_addr, RF_W_wr register-file write port
//   RF_Rp_*, RF_Rq_*   register-file read ports (address, enable)
//   alu_s              00 pass A, 01 A+B, 10 A-B
//   RF_Rp_zero         datapath flag, Rp_data == 0
//   halted             HALT state indicator
//
// Optional: define CTRL_HALT_EN to make opcode 1111 enter a HALT state
// that holds until reset; otherwise 1111 is a NOP and halted is 0.
module cpu_ctrl #(
  parameter int IADDR_W = 16,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IADDR_W-1:0] I_addr,
  output logic               I_rd,
  input  logic [15:0]        I_data,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_rd,
  output logic               D_wr,
  output logic [1:0]         RF_s,
  output logic [7:0]         RF_W_data,
  output logic [3:0]         RF_W_addr,
  output logic               RF_W_wr,
  output logic [3:0]         RF_Rp_addr,
  output logic               RF_Rp_rd,
  output logic [3:0]         RF_Rq_addr,
  output logic               RF_Rq_rd,
  output logic [1:0]         alu_s,
  input  logic               RF_Rp_zero,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_LOADC,
    S_JMPZ,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_LOADC = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMPZ  = 4'h5;
`ifdef CTRL_HALT_EN
  localparam logic [3:0] OP_HALT  = 4'hF;
`endif

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_CON = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [IADDR_W-1:0] ONE = IADDR_W'(1);

  state_t             state;
  logic [IADDR_W-1:0] pc;
  logic [15:0]        ir;

  logic [3:0]         op;
  logic [IADDR_W-1:0] off;

  assign op  = ir[15:12];
  assign off = {{(IADDR_W-8){ir[7]}}, ir[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        S_INIT: state <= S_FETCH;
        S_FETCH: begin
          ir    <= I_data;
          pc    <= pc + ONE;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD:  state <= S_LOAD;
            OP_STORE: state <= S_STORE;
            OP_ADD:   state <= S_ADD;
            OP_LOADC: state <= S_LOADC;
            OP_SUB:   state <= S_SUB;
            OP_JMPZ:  state <= S_JMPZ;
`ifdef CTRL_HALT_EN
            OP_HALT:  state <= S_HALT;
`endif
            default:  state <= S_FETCH;
          endcase
        end
        S_LOAD,
        S_STORE,
        S_ADD,
        S_SUB,
        S_LOADC: state <= S_FETCH;
        S_JMPZ: begin
          state <= RF_Rp_zero ? S_JUMP : S_FETCH;
        end
        S_JUMP: begin
          // PC already points past the JMPZ; the -1 makes
          // the offset relative to the JMPZ itself.
          pc    <= pc + off - ONE;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // Moore decode. Everything is forced quiet while rst is
  // high so an aborted instruction never strobes on the
  // reset edge.
  always_comb begin
    I_addr     = pc;
    I_rd       = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_s       = SRC_ALU;
    RF_W_data  = '0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Rp_addr = '0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_addr = '0;
    RF_Rq_rd   = 1'b0;
    alu_s      = 2'b00;
    halted     = 1'b0;
    if (rst) begin
      I_addr = '0;
    end else begin
      unique case (state)
        S_FETCH: I_rd = 1'b1;
        S_LOAD: begin
          D_addr    = ir[DADDR_W-1:0];
          D_rd      = 1'b1;
          RF_s      = SRC_MEM;
          RF_W_addr = ir[11:8];
          RF_W_wr   = 1'b1;
        end
        S_STORE: begin
          D_addr     = ir[DADDR_W-1:0];
          D_wr       = 1'b1;
          RF_Rp_addr = ir[11:8];
          RF_Rp_rd   = 1'b1;
        end
        S_ADD,
        S_SUB: begin
          RF_Rp_addr = ir[7:4];
          RF_Rp_rd   = 1'b1;
          RF_Rq_addr = ir[3:0];
          RF_Rq_rd   = 1'b1;
          alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
          RF_s       = SRC_ALU;
          RF_W_addr  = ir[11:8];
          RF_W_wr    = 1'b1;
        end
        S_LOADC: begin
          RF_s      = SRC_CON;
          RF_W_data = ir[7:0];
          RF_W_addr = ir[11:8];
          RF_W_wr   = 1'b1;
        end
        S_JMPZ: begin
          RF_Rp_addr = ir[11:8];
          RF_Rp_rd   = 1'b1;
        end
        S_HALT: begin
`ifdef CTRL_HALT_EN
          halted = 1'b1;
`else
          halted = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed vector table, hand sequences and a random
// program checked cycle by cycle against an instruction-level model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data;
  logic [7:0]  d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [1:0]  rf_s;
  logic [7:0]  w_data;
  logic [3:0]  w_addr;
  logic        w_wr;
  logic [3:0]  p_addr;
  logic        p_rd;
  logic [3:0]  q_addr;
  logic        q_rd;
  logic [1:0]  alu_s;
  logic        rp_zero = 1'b0;
  logic        halted;

  logic [15:0] imem [256];

  assign i_data = imem[i_addr[7:0]];

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .I_addr     (i_addr),
    .I_rd       (i_rd),
    .I_data     (i_data),
    .D_addr     (d_addr),
    .D_rd       (d_rd),
    .D_wr       (d_wr),
    .RF_s       (rf_s),
    .RF_W_data  (w_data),
    .RF_W_addr  (w_addr),
    .RF_W_wr    (w_wr),
    .RF_Rp_addr (p_addr),
    .RF_Rp_rd   (p_rd),
    .RF_Rq_addr (q_addr),
    .RF_Rq_rd   (q_rd),
    .alu_s      (alu_s),
    .RF_Rp_zero (rp_zero),
    .halted     (halted)
  );

  typedef struct packed {
    logic        i_rd;
    logic [15:0] i_addr;
    logic [7:0]  d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [1:0]  rf_s;
    logic [7:0]  w_data;
    logic [3:0]  w_addr;
    logic        w_wr;
    logic [3:0]  p_addr;
    logic        p_rd;
    logic [3:0]  q_addr;
    logic        q_rd;
    logic [1:0]  alu_s;
    logic        halted;
  } outs_t;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        z;
    outs_t       ex;
    int          cyc;
    logic [15:0] nxt;
  } tv_t;

  typedef struct {
    logic  z;
    outs_t o;
  } rec_t;

  outs_t got;
  assign got = {i_rd, i_addr, d_addr, d_rd, d_wr, rf_s,
                w_data, w_addr, w_wr, p_addr, p_rd,
                q_addr, q_rd, alu_s, halted};

  int   nchk = 0;
  int   nfail = 0;
  tv_t  tv [11];
  rec_t q [$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input outs_t e);
    nchk++;
    if (got !== e) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, got, e);
    end
  endtask

  task automatic chki(input string nm, input int g, input int e);
    nchk++;
    if (g != e) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", nm, g, e);
    end
  endtask

  function automatic outs_t base(input logic [15:0] a);
    outs_t o;
    o = '0;
    o.i_addr = a;
    return o;
  endfunction

  function automatic outs_t fetch(input logic [15:0] a);
    outs_t o;
    o = base(a);
    o.i_rd = 1'b1;
    return o;
  endfunction

  function automatic outs_t mk(
    input logic [15:0] a,
    input logic [7:0]  da,
    input logic        dr,
    input logic        dw,
    input logic [1:0]  s,
    input logic [7:0]  wd,
    input logic [3:0]  wa,
    input logic        ww,
    input logic [3:0]  pa,
    input logic        pr,
    input logic [3:0]  qa,
    input logic        qr,
    input logic [1:0]  al
  );
    outs_t o;
    o = base(a);
    o.d_addr = da;
    o.d_rd   = dr;
    o.d_wr   = dw;
    o.rf_s   = s;
    o.w_data = wd;
    o.w_addr = wa;
    o.w_wr   = ww;
    o.p_addr = pa;
    o.p_rd   = pr;
    o.q_addr = qa;
    o.q_rd   = qr;
    o.alu_s  = al;
    return o;
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h9000;
  endtask

  // Two reset cycles, then the INIT cycle, then the first fetch.
  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_c0", base(16'h0000));
    step();
    chk("rst_c1", base(16'h0000));
    rst = 1'b0;
    chk("init", base(16'h0000));
    step();
    chk("fetch0", fetch(16'h0000));
  endtask

  task automatic run_vec(input tv_t t);
    int k;
    fill_nop();
    imem[t.pc[7:0]] = t.ins;
    rp_zero = t.z;
    do_reset();
    k = 0;
    while (!(i_rd && i_addr == t.pc) && k < 300) begin
      step();
      k++;
    end
    chk({t.nm, "_fetch"}, fetch(t.pc));
    step();
    chk({t.nm, "_dec"}, base(t.pc + 16'h1));
    k = 1;
    if (t.cyc >= 3) begin
      step();
      k = 2;
      chk({t.nm, "_exec"}, t.ex);
    end
    do begin
      step();
      k++;
    end while (!i_rd && k < 8);
    chki({t.nm, "_cycles"}, k, t.cyc);
    chki({t.nm, "_next"}, int'(i_addr), int'(t.nxt));
  endtask

  // Instruction-level model: expands one instruction into the
  // per-cycle outputs it must produce, returns the next PC.
  task automatic model_instr(
    input  logic [15:0] pc,
    output logic [15:0] nx
  );
    logic [15:0] ir;
    logic [15:0] a;
    logic        z;
    outs_t       e;
    ir = imem[pc[7:0]];
    a  = pc + 16'h1;
    z  = 1'($urandom_range(0, 1));
    nx = a;
    q.push_back('{z, fetch(pc)});
    q.push_back('{z, base(a)});
    e = base(a);
    case (ir[15:12])
      4'h0: begin
        e.d_addr = ir[7:0]; e.d_rd = 1'b1;
        e.rf_s = 2'b01;
        e.w_addr = ir[11:8]; e.w_wr = 1'b1;
        q.push_back('{z, e});
      end
      4'h1: begin
        e.d_addr = ir[7:0]; e.d_wr = 1'b1;
        e.p_addr = ir[11:8]; e.p_rd = 1'b1;
        q.push_back('{z, e});
      end
      4'h2, 4'h4: begin
        e.p_addr = ir[7:4]; e.p_rd = 1'b1;
        e.q_addr = ir[3:0]; e.q_rd = 1'b1;
        e.alu_s = (ir[15:12] == 4'h2) ? 2'b01 : 2'b10;
        e.w_addr = ir[11:8]; e.w_wr = 1'b1;
        q.push_back('{z, e});
      end
      4'h3: begin
        e.rf_s = 2'b10; e.w_data = ir[7:0];
        e.w_addr = ir[11:8]; e.w_wr = 1'b1;
        q.push_back('{z, e});
      end
      4'h5: begin
        e.p_addr = ir[11:8]; e.p_rd = 1'b1;
        q.push_back('{z, e});
        if (z) begin
          q.push_back('{z, base(a)});
          nx = pc + {{8{ir[7]}}, ir[7:0]};
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [15:0] pc;
    logic [15:0] nx;
    logic [3:0]  ops [10];
    logic [31:0] r;

    tv[0] = '{"loadc", 16'h0000, 16'h3205, 1'b0,
      mk(16'h1, 8'h00, 0, 0, 2'b10, 8'h05, 4'h2, 1,
         4'h0, 0, 4'h0, 0, 2'b00), 3, 16'h0001};
    tv[1] = '{"add", 16'h0000, 16'h2123, 1'b0,
      mk(16'h1, 8'h00, 0, 0, 2'b00, 8'h00, 4'h1, 1,
         4'h2, 1, 4'h3, 1, 2'b01), 3, 16'h0001};
    tv[2] = '{"sub", 16'h0000, 16'h4123, 1'b0,
      mk(16'h1, 8'h00, 0, 0, 2'b00, 8'h00, 4'h1, 1,
         4'h2, 1, 4'h3, 1, 2'b10), 3, 16'h0001};
    tv[3] = '{"load", 16'h0000, 16'h0A10, 1'b0,
      mk(16'h1, 8'h10, 1, 0, 2'b01, 8'h00, 4'hA, 1,
         4'h0, 0, 4'h0, 0, 2'b00), 3, 16'h0001};
    tv[4] = '{"store", 16'h0000, 16'h1A22, 1'b0,
      mk(16'h1, 8'h22, 0, 1, 2'b00, 8'h00, 4'h0, 0,
         4'hA, 1, 4'h0, 0, 2'b00), 3, 16'h0001};
    tv[5] = '{"jmpz_t", 16'h0005, 16'h51FD, 1'b1,
      mk(16'h6, 8'h00, 0, 0, 2'b00, 8'h00, 4'h0, 0,
         4'h1, 1, 4'h0, 0, 2'b00), 4, 16'h0002};
    tv[6] = '{"jmpz_n", 16'h0005, 16'h51FD, 1'b0,
      mk(16'h6, 8'h00, 0, 0, 2'b00, 8'h00, 4'h0, 0,
         4'h1, 1, 4'h0, 0, 2'b00), 3, 16'h0006};
    tv[7] = '{"illegal", 16'h0003, 16'h9ABC, 1'b0,
      base(16'h4), 2, 16'h0004};
    tv[8] = '{"loadc_ff", 16'h0002, 16'h3FFF, 1'b0,
      mk(16'h3, 8'h00, 0, 0, 2'b10, 8'hFF, 4'hF, 1,
         4'h0, 0, 4'h0, 0, 2'b00), 3, 16'h0003};
    tv[9] = '{"jmpz_fwd", 16'h0001, 16'h5E7F, 1'b1,
      mk(16'h2, 8'h00, 0, 0, 2'b00, 8'h00, 4'h0, 0,
         4'hE, 1, 4'h0, 0, 2'b00), 4, 16'h0080};
`ifdef CTRL_HALT_EN
    tv[10] = '{"op_e", 16'h0000, 16'hE000, 1'b0,
      base(16'h1), 2, 16'h0001};
`else
    tv[10] = '{"op_f", 16'h0000, 16'hF000, 1'b0,
      base(16'h1), 2, 16'h0001};
`endif

    foreach (tv[i]) run_vec(tv[i]);

    // PC wrap: JMPZ -1 from 0 lands on 0xFFFF, whose fetch
    // must wrap the PC to 0.
    fill_nop();
    imem[0] = 16'h50FF;
    rp_zero = 1'b1;
    do_reset();
    step();
    step();
    step();
    step();
    chk("wrap_fetch", fetch(16'hFFFF));
    step();
    chk("wrap_dec", base(16'h0000));
    step();
    chk("wrap_next", fetch(16'h0000));

    // Reset during a LOAD execute cycle.
    fill_nop();
    imem[0] = 16'h0A10;
    rp_zero = 1'b0;
    do_reset();
    step();
    step();
    chk("mid_load", mk(16'h1, 8'h10, 1, 0, 2'b01, 8'h00,
        4'hA, 1, 4'h0, 0, 4'h0, 0, 2'b00));
    rst = 1'b1;
    #1;
    chk("mid_rst", base(16'h0000));
    step();
    chk("mid_rst_edge", base(16'h0000));
    rst = 1'b0;
    chk("mid_init", base(16'h0000));
    step();
    chk("mid_fetch", fetch(16'h0000));

`ifdef CTRL_HALT_EN
    fill_nop();
    imem[0] = 16'hF000;
    do_reset();
    step();
    for (int i = 0; i < 12; i++) begin
      outs_t h;
      h = base(16'h1);
      h.halted = 1'b1;
      step();
      chk("halt_hold", h);
    end
    do_reset();
`endif

    // Random program against the instruction-level model.
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h5, 4'h7, 4'h9, 4'hF};
`ifdef CTRL_HALT_EN
    ops[9] = 4'hE;
`endif
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      imem[i] = {ops[$urandom_range(0, 9)], r[11:0]};
    end
    q.delete();
    pc = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      model_instr(pc, nx);
      pc = nx;
    end
    do_reset();
    foreach (q[i]) begin
      rp_zero = q[i].z;
      chk("rand", q[i].o);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
